// File: rtl/soc_mem_pkg.sv
// Shared memory-map constants, access-target decode and byte-lane merge helper
// for the data SRAM responder.
package soc_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TIMER,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH,
    SEL_NONE
  } target_e;

  // Anything outside the 64 KB register window falls through to RAM.
  function automatic target_e decode_target(input logic [31:0] addr,
                                            input logic [31:0] base);
    target_e t;
    if (addr[31:16] != base[31:16]) begin
      t = SEL_RAM;
    end else begin
      case (addr[15:0])
        OFF_TIMER:  t = SEL_TIMER;
        OFF_LED:    t = SEL_LED;
        OFF_NUM:    t = SEL_NUM;
        OFF_SWITCH: t = SEL_SWITCH;
        default:    t = SEL_NONE;
      endcase
    end
    return t;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wen);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM request bus between a CPU data port and the responder.
interface data_sram_responder_if;
  // Protocol: no backpressure. A request is taken in every cycle en=1;
  // wen!=0 writes the enabled byte lanes at the next edge, wen=0 reads and
  // rdata carries the result exactly one cycle later, then holds until the
  // next read completes.
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_byte_bank.sv
// Four byte-wide RAM lanes with per-lane write enable and a synchronous,
// read-enabled output register that holds between reads.
module sram_byte_bank #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [2**AW];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (we_i[l]) begin
        mem[addr_i] <= wdata_i[8*l +: 8];
      end
    end

    // Only the output register is cleared; array contents survive reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (re_i) begin
        lane_q <= mem[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = lane_q;
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: address decode, RAM bank, free-running timer, LED/NUM
// registers, switch synchronizer and a one-cycle-latency read path.
module data_sram_responder
  import soc_mem_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  data_sram_responder_if.slave        bus,
  input  logic [7:0]                  switch_in,
  output logic [15:0]                 led_out,
  output logic [31:0]                 num_out
);

  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  target_e     tgt;
  logic        rd_req;
  logic        wr_req;

  assign en    = bus.data_sram_en;
  assign wen   = bus.data_sram_wen;
  assign addr  = bus.data_sram_addr;
  assign wdata = bus.data_sram_wdata;

  assign tgt    = decode_target(addr, MMIO_BASE);
  assign rd_req = !rst && en && (wen == 4'b0000);
  assign wr_req = !rst && en && (wen != 4'b0000);

  logic [31:0] ram_rdata;
  logic [3:0]  ram_we;
  logic        ram_re;

  assign ram_we = (wr_req && tgt == SEL_RAM) ? wen : 4'b0000;
  assign ram_re = rd_req && (tgt == SEL_RAM);

  sram_byte_bank #(.AW(RAM_AW)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr[RAM_AW+1:2]),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        rd_mmio_q, rd_mmio_d;

  // A timer write replaces this cycle's increment; unwritten lanes keep the
  // pre-increment value.
  always_comb begin
    timer_d      = timer_q + 32'd1;
    led_d        = led_q;
    num_d        = num_q;
    mmio_rdata_d = mmio_rdata_q;
    rd_mmio_d    = rd_mmio_q;
    if (wr_req) begin
      case (tgt)
        SEL_TIMER: timer_d = merge_lanes(timer_q, wdata, wen);
        SEL_LED:   led_d   = {wen[1] ? wdata[15:8] : led_q[15:8],
                              wen[0] ? wdata[7:0]  : led_q[7:0]};
        SEL_NUM:   num_d   = merge_lanes(num_q, wdata, wen);
        default:   ;
      endcase
    end
    if (rd_req) begin
      rd_mmio_d = (tgt != SEL_RAM);
      case (tgt)
        SEL_TIMER:  mmio_rdata_d = timer_q;
        SEL_LED:    mmio_rdata_d = {16'h0000, led_q};
        SEL_NUM:    mmio_rdata_d = num_q;
        SEL_SWITCH: mmio_rdata_d = {24'h000000, sync2_q};
        default:    mmio_rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= '0;
      led_q        <= '0;
      num_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      mmio_rdata_q <= '0;
      rd_mmio_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      led_q        <= led_d;
      num_q        <= num_d;
      sync1_q      <= switch_in;
      sync2_q      <= sync1_q;
      mmio_rdata_q <= mmio_rdata_d;
      rd_mmio_q    <= rd_mmio_d;
    end
  end

  // Both sources are registers that only change on a completed read, so the
  // mux output holds across idle and write cycles.
  assign bus.data_sram_rdata = rd_mmio_q ? mmio_rdata_q : ram_rdata;
  assign led_out             = led_q;
  assign num_out             = num_q;

endmodule
